// File: rtl/sync_fifo_pkg.sv
// sync_fifo_flex shared definitions
// default geometry and read-mode encoding
package sync_fifo_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;

   typedef enum logic {
      FIFO_STD  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_e;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: 1W/1R storage array
// read port is registered (std) or combinational (fwft)
module fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int FWFT  = 0,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // storage write; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   if (FWFT == int'(FIFO_FWFT)) begin : g_fwft
      assign rdata = mem[raddr];
   end else begin : g_std
      logic [WIDTH-1:0] rdata_q;
      // registered read, holds between pops
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)  rdata_q <= '0;
         else if (re) rdata_q <= mem[raddr];
      end
      assign rdata = rdata_q;
   end

endmodule

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO
// pointer, status and sticky error logic around fifo_mem
module sync_fifo_flex
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter int FWFT      = 0,
   localparam int PTR_WIDTH = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en,
   input  logic [WIDTH-1:0]   wdata,
   input  logic               rd_en,
   input  logic               err_clr,
   output logic [WIDTH-1:0]   rdata,
   output logic               rd_valid,
   output logic               full,
   output logic               empty,
   output logic               almost_full,
   output logic               almost_empty,
   output logic [PTR_WIDTH:0] count,
   output logic               overflow,
   output logic               underflow
);

   localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(DEPTH);
   localparam logic [PTR_WIDTH:0] AF_CNT   = (PTR_WIDTH+1)'(AF_THRESH);
   localparam logic [PTR_WIDTH:0] AE_CNT   = (PTR_WIDTH+1)'(AE_THRESH);
   localparam bit IS_FWFT = (FWFT == int'(FIFO_FWFT));

   logic [PTR_WIDTH:0] wptr, rptr;
   logic [WIDTH-1:0]   mem_rdata;
   logic               wr_acc, rd_acc;
   logic               rd_valid_q;

   // status is a pure function of the registered pointers
   assign count        = wptr - rptr;
   assign full         = (count == FULL_CNT);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_CNT);
   assign almost_empty = (count <= AE_CNT);

   // a pop frees a slot, so a full FIFO may still take a write
   assign rd_acc = rd_en && !empty;
   assign wr_acc = wr_en && (!full || rd_acc);

   // pointer advance, wrapping at 2*DEPTH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_acc) wptr <= wptr + 1'b1;
         if (rd_acc) rptr <= rptr + 1'b1;
      end
   end

   // sticky errors; a new rejection beats err_clr
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && !wr_acc) overflow <= 1'b1;
         else if (err_clr)     overflow <= 1'b0;
         if (rd_en && !rd_acc) underflow <= 1'b1;
         else if (err_clr)     underflow <= 1'b0;
      end
   end

   // one-cycle valid strobe following each standard-mode pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_valid_q <= 1'b0;
      else        rd_valid_q <= rd_acc && !IS_FWFT;
   end

   assign rd_valid = IS_FWFT ? !empty : rd_valid_q;
   assign rdata    = (IS_FWFT && empty) ? '0 : mem_rdata;

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .FWFT  (FWFT)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_acc),
      .waddr (wptr[PTR_WIDTH-1:0]),
      .wdata (wdata),
      .re    (rd_acc),
      .raddr (rptr[PTR_WIDTH-1:0]),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: directed vectors plus scoreboarded sequences
// std-mode and fwft-mode instances share clock and reset
module tb_sync_fifo_flex;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
   logic [7:0] wdata = '0;
   logic [7:0] rdata;
   logic       rd_valid, full, empty, almost_full, almost_empty;
   logic [4:0] count;
   logic       overflow, underflow;

   logic       f_wr_en = 1'b0, f_rd_en = 1'b0, f_err_clr = 1'b0;
   logic [7:0] f_wdata = '0;
   logic [7:0] f_rdata;
   logic       f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty;
   logic [4:0] f_count;
   logic       f_overflow, f_underflow;

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   sync_fifo_flex #(.WIDTH(8), .DEPTH(16), .FWFT(0)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .wdata        (wdata),
      .rd_en        (rd_en),
      .err_clr      (err_clr),
      .rdata        (rdata),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   sync_fifo_flex #(.WIDTH(8), .DEPTH(16), .FWFT(1)) dut_f (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (f_wr_en),
      .wdata        (f_wdata),
      .rd_en        (f_rd_en),
      .err_clr      (f_err_clr),
      .rdata        (f_rdata),
      .rd_valid     (f_rd_valid),
      .full         (f_full),
      .empty        (f_empty),
      .almost_full  (f_almost_full),
      .almost_empty (f_almost_empty),
      .count        (f_count),
      .overflow     (f_overflow),
      .underflow    (f_underflow)
   );

   typedef struct {
      logic       wr, rd, clr;
      logic [7:0] d;
      int         cnt;
      logic       fu, em, af, ae, ov, un, rv;
      logic [7:0] rdat;
   } vec_t;

   vec_t v[11];
   logic [7:0] q[$];
   logic [7:0] exp_d;
   logic       m_ov, m_un;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else
         passed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic r, input logic c,
                        input logic [7:0] d);
      wr_en = w;
      rd_en = r;
      err_clr = c;
      wdata = d;
      tick();
   endtask

   task automatic do_reset();
      wr_en = 0; rd_en = 0; err_clr = 0;
      f_wr_en = 0; f_rd_en = 0; f_err_clr = 0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_af", almost_full, 0);
      chk("rst_ae", almost_empty, 1);
      chk("rst_ov", overflow, 0);
      chk("rst_un", underflow, 0);
      chk("rst_rv", rd_valid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_f_empty", f_empty, 1);
      chk("rst_f_rv", f_rd_valid, 0);
      tick();
      tick();
      rst_n = 1'b1;
      q.delete();
      m_ov = 0;
      m_un = 0;
   endtask

   initial begin
      v[0]  = '{0,1,0,8'h00, 0,0,1,0,1,0,1,0,8'h00};
      v[1]  = '{0,0,1,8'h00, 0,0,1,0,1,0,0,0,8'h00};
      v[2]  = '{1,1,0,8'h11, 1,0,0,0,1,0,1,0,8'h00};
      v[3]  = '{1,0,1,8'h22, 2,0,0,0,1,0,0,0,8'h00};
      v[4]  = '{1,0,0,8'h33, 3,0,0,0,0,0,0,0,8'h00};
      v[5]  = '{0,1,0,8'h00, 2,0,0,0,1,0,0,1,8'h11};
      v[6]  = '{0,0,0,8'h00, 2,0,0,0,1,0,0,0,8'h11};
      v[7]  = '{1,1,0,8'h44, 2,0,0,0,1,0,0,1,8'h22};
      v[8]  = '{0,1,0,8'h00, 1,0,0,0,1,0,0,1,8'h33};
      v[9]  = '{0,1,0,8'h00, 0,0,1,0,1,0,0,1,8'h44};
      v[10] = '{0,0,0,8'h00, 0,0,1,0,1,0,0,0,8'h44};

      tick();
      do_reset();

      for (int i = 0; i < 11; i++) begin
         drive(v[i].wr, v[i].rd, v[i].clr, v[i].d);
         chk($sformatf("v%0d_count", i), count, v[i].cnt);
         chk($sformatf("v%0d_full", i), full, v[i].fu);
         chk($sformatf("v%0d_empty", i), empty, v[i].em);
         chk($sformatf("v%0d_af", i), almost_full, v[i].af);
         chk($sformatf("v%0d_ae", i), almost_empty, v[i].ae);
         chk($sformatf("v%0d_ov", i), overflow, v[i].ov);
         chk($sformatf("v%0d_un", i), underflow, v[i].un);
         chk($sformatf("v%0d_rv", i), rd_valid, v[i].rv);
         chk($sformatf("v%0d_rdata", i), rdata, v[i].rdat);
      end

      do_reset();
      for (int i = 1; i <= 16; i++) begin
         exp_d = 8'($urandom);
         q.push_back(exp_d);
         drive(1, 0, 0, exp_d);
         chk($sformatf("fill%0d_count", i), count, i);
         chk($sformatf("fill%0d_af", i), almost_full, i >= 14);
         chk($sformatf("fill%0d_full", i), full, i == 16);
      end
      drive(1, 0, 0, 8'hEE);
      chk("ovf_count", count, 16);
      chk("ovf_flag", overflow, 1);
      drive(0, 0, 1, 8'h00);
      chk("ovf_clr", overflow, 0);

      for (int i = 0; i < 5; i++) begin
         exp_d = 8'($urandom);
         q.push_back(exp_d);
         drive(1, 1, 0, exp_d);
         exp_d = q.pop_front();
         chk($sformatf("conc%0d_count", i), count, 16);
         chk($sformatf("conc%0d_ov", i), overflow, 0);
         chk($sformatf("conc%0d_rv", i), rd_valid, 1);
         chk($sformatf("conc%0d_rdata", i), rdata, exp_d);
      end

      for (int i = 15; i >= 0; i--) begin
         drive(0, 1, 0, 8'h00);
         exp_d = q.pop_front();
         chk($sformatf("drain%0d_rdata", i), rdata, exp_d);
         chk($sformatf("drain%0d_rv", i), rd_valid, 1);
         chk($sformatf("drain%0d_ae", i), almost_empty, i <= 2);
         chk($sformatf("drain%0d_empty", i), empty, i == 0);
      end
      drive(0, 0, 0, 8'h00);
      chk("drain_rv_drop", rd_valid, 0);

      do_reset();
      drive(0, 1, 0, 8'h00);
      chk("unf_flag", underflow, 1);
      chk("unf_count", count, 0);
      chk("unf_rv", rd_valid, 0);

      do_reset();
      chk("fwft_idle_rv", f_rd_valid, 0);
      f_wr_en = 1; f_wdata = 8'hA5;
      tick();
      f_wr_en = 0;
      chk("fwft_rdata", f_rdata, 8'hA5);
      chk("fwft_rv", f_rd_valid, 1);
      tick();
      chk("fwft_hold", f_rdata, 8'hA5);
      f_rd_en = 1;
      tick();
      f_rd_en = 0;
      chk("fwft_pop_empty", f_empty, 1);
      chk("fwft_pop_rv", f_rd_valid, 0);

      do_reset();
      for (int op = 0; op < 100; op++) begin
         logic w, r, c, ra, wa;
         int n;
         if (op == 50) do_reset();
         w = ($urandom_range(0, 9) < 6);
         r = ($urandom_range(0, 9) < 5);
         c = ($urandom_range(0, 9) == 0);
         exp_d = 8'($urandom);
         n = q.size();
         ra = r && (n > 0);
         wa = w && ((n < 16) || ra);
         if (w && !wa) m_ov = 1; else if (c) m_ov = 0;
         if (r && !ra) m_un = 1; else if (c) m_un = 0;
         drive(w, r, c, exp_d);
         if (ra) begin
            logic [7:0] e;
            e = q.pop_front();
            chk($sformatf("rnd%0d_rdata", op), rdata, e);
         end
         if (wa) q.push_back(exp_d);
         chk($sformatf("rnd%0d_rv", op), rd_valid, ra);
         chk($sformatf("rnd%0d_count", op), count, q.size());
         chk($sformatf("rnd%0d_full", op), full, q.size() == 16);
         chk($sformatf("rnd%0d_empty", op), empty, q.size() == 0);
         chk($sformatf("rnd%0d_ov", op), overflow, m_ov);
         chk($sformatf("rnd%0d_un", op), underflow, m_un);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
